// File: rtl/conv1_frame_ctrl_pkg.sv
// rtl/conv1_frame_ctrl_pkg.sv - shared state encoding, counter widths and geometry helpers
package conv1_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int IDX_BITS   = 5;
  localparam int TOTAL_BITS = 10;

  // Default-geometry constants; the modules re-derive them from their own parameters.
  localparam int DEF_OW   = 24;
  localparam int DEF_OH   = 24;
  localparam int DEF_NPIX = 28 * 28;
  localparam int DEF_NOUT = DEF_OW * DEF_OH;

  function automatic int out_dim(input int n, input int k);
    return n - k + 1;
  endfunction

endpackage

// File: rtl/conv1_frame_ctrl_out_tracker.sv
// rtl/conv1_frame_ctrl_out_tracker.sv - row/col/total counters for conv1 valid outputs
module conv1_out_tracker
  import conv1_frame_ctrl_pkg::*;
#(
  parameter int OW = DEF_OW,
  parameter int OH = DEF_OH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  active,
  input  logic                  valid,
  output logic [IDX_BITS-1:0]   out_row,
  output logic [IDX_BITS-1:0]   out_col,
  output logic [TOTAL_BITS-1:0] total,
  output logic                  overflow
);

  logic [IDX_BITS-1:0] row_cnt;
  logic [IDX_BITS-1:0] col_cnt;
  logic                hit;
  logic                full;

  assign hit      = active && valid;
  assign full     = total == TOTAL_BITS'(OW * OH);
  assign overflow = hit && full;

  // Once full, further valids leave every counter and the presented index untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt <= '0;
      col_cnt <= '0;
      out_row <= '0;
      out_col <= '0;
      total   <= '0;
    end else if (clear) begin
      row_cnt <= '0;
      col_cnt <= '0;
      out_row <= '0;
      out_col <= '0;
      total   <= '0;
    end else if (hit && !full) begin
      out_row <= row_cnt;
      out_col <= col_cnt;
      total   <= total + 1'b1;
      if (col_cnt == IDX_BITS'(OW - 1)) begin
        col_cnt <= '0;
        row_cnt <= row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv1_frame_ctrl.sv
// rtl/conv1_frame_ctrl.sv - per-frame sequencer feeding one image into the conv1 layer
module conv1_frame_ctrl
  import conv1_frame_ctrl_pkg::*;
#(
  parameter int WIDTH      = 28,
  parameter int HEIGHT     = 28,
  parameter int DATA_BITS  = 8,
  parameter int K          = 5,
  parameter int ADDR_BITS  = 10,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 frame_err,
  output logic                 img_rd_en,
  output logic [ADDR_BITS-1:0] img_addr,
  input  logic [DATA_BITS-1:0] img_data,
  output logic                 layer_rst_n,
  output logic [DATA_BITS-1:0] layer_data_in,
  input  logic                 valid_out_conv,
  output logic [4:0]           out_row,
  output logic [4:0]           out_col
);

  localparam int OW        = out_dim(WIDTH, K);
  localparam int OH        = out_dim(HEIGHT, K);
  localparam int NPIX      = WIDTH * HEIGHT;
  localparam int NOUT      = OW * OH;
  localparam int CLR_BITS  = $clog2(CLR_CYCLES + 1);
  localparam int IDLE_BITS = $clog2(TIMEOUT + 1);

  state_t                state, state_nxt;
  logic [CLR_BITS-1:0]   clr_cnt;
  logic [IDLE_BITS-1:0]  idle_cnt;
  logic [TOTAL_BITS-1:0] total;
  logic                  feed_d, accept, last_pix, timeout, all_out, overflow;

  assign accept   = (state == S_IDLE) && start;
  assign last_pix = img_addr == ADDR_BITS'(NPIX - 1);
  assign timeout  = idle_cnt == IDLE_BITS'(TIMEOUT);
  assign all_out  = total == TOTAL_BITS'(NOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CLR;
      S_CLR:   if (clr_cnt == CLR_BITS'(CLR_CYCLES - 1)) state_nxt = S_FEED;
      S_FEED:  if (last_pix) state_nxt = S_DRAIN;
      S_DRAIN: if (all_out || timeout) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    img_rd_en   = 1'b0;
    layer_rst_n = 1'b0;
    case (state)
      S_CLR:   busy = 1'b1;
      S_FEED:  begin busy = 1'b1; img_rd_en = 1'b1; layer_rst_n = 1'b1; end
      S_DRAIN: begin busy = 1'b1; layer_rst_n = 1'b1; end
      S_DONE:  begin busy = 1'b1; done = 1'b1; end
      default: busy = 1'b0;
    endcase
  end

  // feed_d lines up with the RAM's one-cycle read latency, so pixels land two cycles after their address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt       <= '0;
      idle_cnt      <= '0;
      img_addr      <= '0;
      feed_d        <= 1'b0;
      layer_data_in <= '0;
      frame_err     <= 1'b0;
    end else begin
      feed_d        <= state == S_FEED;
      layer_data_in <= feed_d ? img_data : '0;
      clr_cnt       <= (state == S_CLR) ? clr_cnt + 1'b1 : '0;
      if (state == S_FEED) img_addr <= last_pix ? '0 : img_addr + 1'b1;
      else                 img_addr <= '0;
      if (state != S_DRAIN)    idle_cnt <= '0;
      else if (valid_out_conv) idle_cnt <= '0;
      else if (!timeout)       idle_cnt <= idle_cnt + 1'b1;
      if (accept)
        frame_err <= 1'b0;
      else if (overflow || (state == S_DRAIN && timeout && !all_out))
        frame_err <= 1'b1;
    end
  end

  conv1_out_tracker #(
    .OW(OW),
    .OH(OH)
  ) u_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept),
    .active   (state == S_FEED || state == S_DRAIN),
    .valid    (valid_out_conv),
    .out_row  (out_row),
    .out_col  (out_col),
    .total    (total),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_conv1_frame_ctrl.sv
// tb/tb_conv1_frame_ctrl.sv - randomized scoreboard bench for conv1_frame_ctrl
module tb_conv1_frame_ctrl;

  localparam int W = 28, H = 28, K = 5;
  localparam int OW = W - K + 1, OH = H - K + 1;
  localparam int NPIX = W * H, NOUT = OW * OH;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic       busy, done, frame_err, img_rd_en, layer_rst_n;
  logic       valid_out_conv = 1'b0;
  logic [9:0] img_addr;
  logic [7:0] img_data = '0, layer_data_in;
  logic [4:0] out_row, out_col;

  int total = 0, bad = 0, cyc = 0;
  logic [7:0] img [NPIX];
  int exp_rc_q[$];
  int pix_q[$];
  int n_valid = 0, emitted = 0, on_cnt = 0, last_v = 0, gap_cnt = 0;
  int exp_addr = 0, drain_cyc = 0, done_cnt = 0, done_cyc = 0;
  logic rd_d1 = 1'b0, rd_d2 = 1'b0, in_feed = 1'b0, mv;
  int me;

  conv1_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .frame_err(frame_err), .img_rd_en(img_rd_en), .img_addr(img_addr),
    .img_data(img_data), .layer_rst_n(layer_rst_n), .layer_data_in(layer_data_in),
    .valid_out_conv(valid_out_conv), .out_row(out_row), .out_col(out_col)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous image RAM: data is available the cycle after the read.
  always @(posedge clk) if (img_rd_en) img_data <= img[img_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Layer model: after a warm-up, emits n_valid valids with random single-cycle gaps.
  initial forever begin
    @(posedge clk); #1;
    valid_out_conv = 1'b0;
    if (rst_n && layer_rst_n) begin
      on_cnt++;
      if (on_cnt >= 120 && emitted < n_valid) begin
        if (gap_cnt > 0) gap_cnt--;
        else begin
          valid_out_conv = 1'b1;
          exp_rc_q.push_back(emitted < NOUT ? (emitted / OW) * 32 + emitted % OW
                                            : (OH - 1) * 32 + (OW - 1));
          emitted++;
          last_v = cyc;
          gap_cnt = (emitted + 1 >= NOUT) ? 0 : ($urandom_range(0, 3) == 0 ? 1 : 0);
        end
      end
    end else on_cnt = 0;
  end

  // Row/col monitor: the index for a valid shows up one cycle later.
  initial forever begin
    @(posedge clk);
    mv = valid_out_conv && rst_n;
    #2;
    if (mv && rst_n) begin
      if (exp_rc_q.size() == 0) check("rc_unexpected", 1, 0);
      else begin
        me = exp_rc_q.pop_front();
        check("out_row", out_row, me / 32);
        check("out_col", out_col, me % 32);
      end
    end
  end

  // Feed monitor: raster addresses and the pixel stream two cycles behind them.
  initial forever begin
    @(posedge clk); #2;
    if (rst_n) begin
      if (img_rd_en) begin
        check("img_addr", img_addr, exp_addr);
        pix_q.push_back(exp_addr < NPIX ? int'(img[exp_addr]) : 0);
        exp_addr++;
        in_feed = 1'b1;
      end else if (in_feed) begin
        in_feed = 1'b0;
        drain_cyc = cyc;
      end
      if (rd_d2) begin
        if (pix_q.size() == 0) check("pix_unexpected", 1, 0);
        else check("layer_data_in", layer_data_in, pix_q.pop_front());
      end else check("layer_data_idle", layer_data_in, 0);
      rd_d2 = rd_d1;
      rd_d1 = img_rd_en;
    end
  end

  initial forever begin
    @(posedge clk); #2;
    if (rst_n && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic load_image(input bit ramp);
    for (int i = 0; i < NPIX; i++) img[i] = ramp ? 8'(i % 256) : 8'($urandom_range(0, 255));
  endtask

  task automatic start_frame(input int nval);
    n_valid = nval; emitted = 0; exp_addr = 0; gap_cnt = 0;
    check("busy_before_start", busy, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("err_cleared", frame_err, 0);
    check("layer_rst_c1", layer_rst_n, 0);
    @(posedge clk); #1;
    check("layer_rst_c2", layer_rst_n, 0);
    @(posedge clk); #1;
    check("layer_rst_feed", layer_rst_n, 1);
  endtask

  task automatic wait_done(input bit poke);
    int n;
    for (n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      start = poke && img_rd_en && (img_addr == 10'd300);
      if (done) break;
    end
    start = 1'b0;
    check("done_seen", n < 3000, 1);
    check("busy_at_done", busy, 1);
    if (poke) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("done_start_ignored", busy, 0);
    end else begin
      @(posedge clk); #1;
      check("busy_fall", busy, 0);
    end
  endtask

  task automatic run_frame(input bit ramp, input int nval, input bit poke, input bit exp_err);
    int dc0;
    load_image(ramp);
    dc0 = done_cnt;
    start_frame(nval);
    wait_done(poke);
    check("frame_err", frame_err, exp_err);
    check("done_once", done_cnt - dc0, 1);
    check("addr_count", exp_addr, NPIX);
    check("rc_drained", exp_rc_q.size(), 0);
    check("pix_drained", pix_q.size(), 0);
  endtask

  initial begin
    int lat, base, n, dc0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", frame_err, 0);
    check("rst_rd_en", img_rd_en, 0);
    check("rst_addr", img_addr, 0);
    check("rst_layer_rst", layer_rst_n, 0);
    check("rst_data", layer_data_in, 0);
    check("rst_row", out_row, 0);
    check("rst_col", out_col, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame(1'b1, NOUT, 1'b1, 1'b0);
    run_frame(1'b0, NOUT, 1'b0, 1'b0);

    run_frame(1'b0, 500, 1'b0, 1'b1);
    base = (drain_cyc > last_v + 1) ? drain_cyc : last_v + 1;
    lat = done_cyc - base;
    check("timeout_latency", (lat >= TIMEOUT && lat <= TIMEOUT + 2), 1);

    run_frame(1'b0, NOUT + 1, 1'b0, 1'b1);
    check("sat_row", out_row, OH - 1);
    check("sat_col", out_col, OW - 1);

    load_image(1'b0);
    start_frame(NOUT);
    n = 0;
    while (!(img_rd_en && img_addr == 10'd400) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("reached_400", img_addr, 400);
    dc0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_err", frame_err, 0);
    check("mid_rd_en", img_rd_en, 0);
    check("mid_addr", img_addr, 0);
    check("mid_layer_rst", layer_rst_n, 0);
    check("mid_data", layer_data_in, 0);
    check("mid_row", out_row, 0);
    check("mid_col", out_col, 0);
    repeat (4) @(posedge clk);
    #1;
    exp_rc_q.delete(); pix_q.delete();
    rd_d1 = 1'b0; rd_d2 = 1'b0; in_feed = 1'b0; exp_addr = 0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_done_after_reset", done_cnt - dc0, 0);

    run_frame(1'b0, NOUT, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
